zombie_place_generator: RTL and testbench

- Game engine that produces the 8-bit `place` lane vector and the `flag` blank/clear line consumed by the dot-matrix row-scan displayer.
- `place` holds four 2-bit bands:
  - place[7:6] = band 0 (top), place[5:4] = band 1, place[3:2] = band 2: zombie lanes.
  - place[1:0] = band 3: player lane.
- Zombies scroll down one band per step. The player dodges with left/right buttons. Lives, score and speed-up are tracked here.

---
 rtl/zombie_place_generator.sv | 140 ++++++++++++++
 tb/tb_zombie_place_generator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zombie_place_generator.sv
// Lane-dodging game engine: scrolls LFSR-chosen zombie lanes down three bands,
// moves the player lane from debounced-by-sync buttons, tracks lives/score/speed.
module zombie_place_generator #(
  parameter logic [7:0] STEP_TICKS = 8'd250,
  parameter logic [7:0] STEP_DEC   = 8'd25,
  parameter logic [7:0] STEP_MIN   = 8'd50,
  parameter logic [1:0] LIVES      = 2'd3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [7:0] place,
  output logic       flag,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, CLEAR, PLAY, OVER} state_t;

  state_t     state, state_n;
  logic [2:0] start_sr, left_sr, right_sr;
  logic [7:0] lfsr;
  logic [7:0] interval, interval_n;
  logic [7:0] tick, tick_n;
  logic [7:0] place_n, score_n;
  logic [1:0] lives_n;
  logic       flag_n, game_over_n;

  logic       start_edge, left_edge, right_edge;
  logic [1:0] lane_moved;
  logic       step, hit;
  logic [7:0] score_inc;
  logic [8:0] interval_sub;
  logic [7:0] interval_dec;

  // Bits [1:0] form the 2-FF synchronizer; bit 2 delays the synced level for edge detection.
  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      start_sr <= 3'b000;
      left_sr  <= 3'b000;
      right_sr <= 3'b000;
      lfsr     <= LFSR_SEED;
    end else begin
      start_sr <= {start_sr[1:0], start};
      left_sr  <= {left_sr[1:0], btn_left};
      right_sr <= {right_sr[1:0], btn_right};
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign start_edge = start_sr[1] & ~start_sr[2];
  assign left_edge  = left_sr[1] & ~left_sr[2];
  assign right_edge = right_sr[1] & ~right_sr[2];

  always_comb begin
    lane_moved = place[1:0];
    if (left_edge && !right_edge && place[1:0] != 2'd0)
      lane_moved = place[1:0] - 2'd1;
    else if (right_edge && !left_edge && place[1:0] != 2'd3)
      lane_moved = place[1:0] + 2'd1;
  end

  assign step         = (tick == interval - 8'd1);
  assign hit          = (place[3:2] == lane_moved);
  assign score_inc    = (score == 8'hFF) ? score : score + 8'd1;
  // Nine bits so a wrap below zero shows up in the top bit before clamping.
  assign interval_sub = {1'b0, interval} - {1'b0, STEP_DEC};
  assign interval_dec = (interval_sub[8] || interval_sub[7:0] < STEP_MIN) ? STEP_MIN : interval_sub[7:0];

  always_comb begin
    state_n    = state;
    place_n    = place;
    score_n    = score;
    lives_n    = lives;
    interval_n = interval;
    tick_n     = tick;
    case (state)
      IDLE: if (start_edge) state_n = CLEAR;
      CLEAR: begin
        score_n    = 8'd0;
        lives_n    = LIVES;
        interval_n = STEP_TICKS;
        tick_n     = 8'd0;
        place_n    = {lfsr[1:0], lfsr[3:2], lfsr[5:4], 2'b01};
        state_n    = PLAY;
      end
      PLAY: begin
        if (start_edge) begin
          state_n = CLEAR;
        end else begin
          place_n[1:0] = lane_moved;
          if (step) begin
            tick_n       = 8'd0;
            place_n[7:2] = {lfsr[1:0], place[7:4]};
            if (hit) begin
              lives_n = lives - 2'd1;
              if (lives_n == 2'd0) state_n = OVER;
            end else begin
              score_n = score_inc;
              if (score_inc[2:0] == 3'd0 && score_inc != 8'hFF) interval_n = interval_dec;
            end
          end else begin
            tick_n = tick + 8'd1;
          end
        end
      end
      OVER: if (start_edge) state_n = CLEAR;
      default: state_n = IDLE;
    endcase
    flag_n      = (state_n != PLAY);
    game_over_n = (state_n == OVER);
  end

  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      place     <= 8'h00;
      flag      <= 1'b1;
      score     <= 8'd0;
      lives     <= LIVES;
      game_over <= 1'b0;
      interval  <= STEP_TICKS;
      tick      <= 8'd0;
    end else begin
      state     <= state_n;
      place     <= place_n;
      flag      <= flag_n;
      score     <= score_n;
      lives     <= lives_n;
      game_over <= game_over_n;
      interval  <= interval_n;
      tick      <= tick_n;
    end
  end

endmodule

// File: tb/tb_zombie_place_generator.sv
// Bench for zombie_place_generator: a cycle model fills a scoreboard queue on
// every clock, the monitor drains it on the falling edge; directed checks cover the game flow.
module tb_zombie_place_generator;

  localparam logic [7:0] STEP_TICKS = 8'd100;
  localparam logic [7:0] STEP_DEC   = 8'd25;
  localparam logic [7:0] STEP_MIN   = 8'd50;
  localparam logic [1:0] LIVES      = 2'd3;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam int S_IDLE = 0, S_CLEAR = 1, S_PLAY = 2, S_OVER = 3;

  logic clk_div = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic [7:0] place;
  logic       flag;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int check_count = 0;
  int pass_count = 0;
  logic [19:0] exp_q[$];

  // Reference game model, one call per rising clock.
  int         m_state = S_IDLE;
  logic [2:0] m_st = 3'b000, m_lt = 3'b000, m_rt = 3'b000;
  logic [7:0] m_lfsr = LFSR_SEED;
  logic [7:0] m_place = 8'h00;
  logic [7:0] m_score = 8'd0;
  logic [7:0] m_interval = STEP_TICKS;
  logic [7:0] m_tick = 8'd0;
  logic [1:0] m_lives = LIVES;
  logic       m_flag = 1'b1;
  logic       m_go = 1'b0;
  int         m_steps = 0;

  zombie_place_generator #(
    .STEP_TICKS(STEP_TICKS), .STEP_DEC(STEP_DEC), .STEP_MIN(STEP_MIN),
    .LIVES(LIVES), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk_div(clk_div), .reset(reset), .start(start), .btn_left(btn_left),
    .btn_right(btn_right), .place(place), .flag(flag), .score(score),
    .lives(lives), .game_over(game_over)
  );

  always #5 clk_div = ~clk_div;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  task automatic modelCycle();
    logic st_e, l_e, r_e;
    logic [1:0] lane;
    int nxt, iv;
    st_e = m_st[1] & ~m_st[2];
    l_e  = m_lt[1] & ~m_lt[2];
    r_e  = m_rt[1] & ~m_rt[2];
    m_st = {m_st[1:0], start};
    m_lt = {m_lt[1:0], btn_left};
    m_rt = {m_rt[1:0], btn_right};
    nxt = m_state;
    case (m_state)
      S_IDLE, S_OVER: if (st_e) nxt = S_CLEAR;
      S_CLEAR: begin
        m_score = 8'd0;
        m_lives = LIVES;
        m_interval = STEP_TICKS;
        m_tick = 8'd0;
        m_place = {m_lfsr[1:0], m_lfsr[3:2], m_lfsr[5:4], 2'b01};
        nxt = S_PLAY;
      end
      S_PLAY: begin
        if (st_e) nxt = S_CLEAR;
        else begin
          lane = m_place[1:0];
          if (l_e && !r_e) lane = (lane == 2'd0) ? 2'd0 : lane - 2'd1;
          if (r_e && !l_e) lane = (lane == 2'd3) ? 2'd3 : lane + 2'd1;
          if (int'(m_tick) == int'(m_interval) - 1) begin
            if (m_place[3:2] == lane) begin
              m_lives = m_lives - 2'd1;
              if (m_lives == 2'd0) nxt = S_OVER;
            end else begin
              if (m_score != 8'hFF) m_score = m_score + 8'd1;
              if (m_score[2:0] == 3'd0 && m_score != 8'hFF) begin
                iv = int'(m_interval) - int'(STEP_DEC);
                m_interval = (iv < int'(STEP_MIN)) ? STEP_MIN : 8'(iv);
              end
            end
            m_place = {m_lfsr[1:0], m_place[7:4], lane};
            m_tick = 8'd0;
            m_steps++;
          end else begin
            m_place[1:0] = lane;
            m_tick = m_tick + 8'd1;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
    m_state = nxt;
    m_flag = (nxt != S_PLAY);
    m_go = (nxt == S_OVER);
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  always @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      m_state = S_IDLE; m_st = 3'b000; m_lt = 3'b000; m_rt = 3'b000;
      m_lfsr = LFSR_SEED; m_place = 8'h00; m_score = 8'd0; m_interval = STEP_TICKS;
      m_tick = 8'd0; m_lives = LIVES; m_flag = 1'b1; m_go = 1'b0;
    end else begin
      modelCycle();
    end
    if (clk_div) exp_q.push_back({m_place, m_flag, m_score, m_lives, m_go});
  end

  always @(negedge clk_div) begin : monitor
    logic [19:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checkOutput("cycle", 32'({place, flag, score, lives, game_over}), 32'(exp_v));
    end
  end

  // Called at a falling edge; leaves the button idle long enough for the next edge.
  task automatic applyStimulus(input logic s, input logic l, input logic r, input int hold);
    start = s; btn_left = l; btn_right = r;
    repeat (hold) @(negedge clk_div);
    start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (3) @(negedge clk_div);
  endtask

  task automatic moveTo(input logic [1:0] target);
    for (int k = 0; k < 4 && m_place[1:0] != target; k++)
      applyStimulus(1'b0, target < m_place[1:0], target > m_place[1:0], 2);
  endtask

  task automatic waitStep();
    int s0, n;
    s0 = m_steps;
    n = 0;
    while (m_steps == s0 && n < 400) begin
      @(negedge clk_div);
      n++;
    end
    if (m_steps == s0) checkOutput("step_wait", 32'(n), 32'(0));
  endtask

  task automatic waitPlay();
    for (int n = 0; n < 20 && flag !== 1'b0; n++) @(negedge clk_div);
    checkOutput("enter_play", 32'(flag), 32'(0));
  endtask

  int right_exp[3] = '{2, 3, 3};
  int left_exp[4] = '{2, 1, 0, 0};
  logic [7:0] frozen_place;

  initial begin
    repeat (3) @(negedge clk_div);
    reset = 1'b1;
    repeat (10) @(negedge clk_div);
    checkOutput("rst_place", 32'(place), 32'h00);
    checkOutput("rst_flag", 32'(flag), 32'(1));
    checkOutput("rst_lives", 32'(lives), 32'(3));
    checkOutput("rst_score", 32'(score), 32'(0));
    checkOutput("rst_over", 32'(game_over), 32'(0));

    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    waitPlay();
    checkOutput("start_lane", 32'(place[1:0]), 32'(1));
    foreach (right_exp[i]) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      checkOutput("right_lane", 32'(place[1:0]), 32'(right_exp[i]));
    end
    foreach (left_exp[i]) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 2);
      checkOutput("left_lane", 32'(place[1:0]), 32'(left_exp[i]));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 2);
    checkOutput("both_lane", 32'(place[1:0]), 32'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, 20);
    checkOutput("hold_lane", 32'(place[1:0]), 32'(2));

    // Asynchronous reset in the middle of a game.
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_place", 32'(place), 32'h00);
    checkOutput("mid_rst_flag", 32'(flag), 32'(1));
    checkOutput("mid_rst_lives", 32'(lives), 32'(3));
    checkOutput("mid_rst_score", 32'(score), 32'(0));
    checkOutput("mid_rst_over", 32'(game_over), 32'(0));
    repeat (2) @(negedge clk_div);
    reset = 1'b1;
    repeat (3) @(negedge clk_div);

    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    waitPlay();
    checkOutput("new_lives", 32'(lives), 32'(3));
    for (int h = 0; h < 3; h++) begin
      moveTo(m_place[3:2]);
      waitStep();
      checkOutput("hit_lives", 32'(lives), 32'(2 - h));
      checkOutput("hit_score", 32'(score), 32'(0));
    end
    checkOutput("over_flag", 32'(flag), 32'(1));
    checkOutput("over_go", 32'(game_over), 32'(1));
    frozen_place = m_place;
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    repeat (150) @(negedge clk_div);
    checkOutput("over_place", 32'(place), 32'(frozen_place));
    checkOutput("over_lives", 32'(lives), 32'(0));

    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    waitPlay();
    checkOutput("restart_score", 32'(score), 32'(0));
    checkOutput("restart_lives", 32'(lives), 32'(3));
    checkOutput("restart_go", 32'(game_over), 32'(0));

    for (int d = 1; d <= 24; d++) begin
      moveTo(m_place[3:2] ^ 2'b01);
      waitStep();
      if (d % 8 == 0) begin
        checkOutput("dodge_score", 32'(score), 32'(d));
        checkOutput("dodge_interval", 32'(dut.interval), 32'((d == 8) ? 75 : 50));
      end
    end

    // Start edge lands in the same cycle as a step: restart must win.
    moveTo(m_place[3:2] ^ 2'b01);
    for (int n = 0; n < 200 && int'(m_tick) != int'(m_interval) - 3; n++) @(negedge clk_div);
    start = 1'b1;
    repeat (3) @(negedge clk_div);
    checkOutput("coinc_flag", 32'(flag), 32'(1));
    checkOutput("coinc_score", 32'(score), 32'(24));
    checkOutput("coinc_lives", 32'(lives), 32'(3));
    start = 1'b0;
    waitPlay();
    checkOutput("coinc_clear", 32'(score), 32'(0));

    @(negedge clk_div);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
